rr_mux: RTL
===========

# rr_mux

Parametrised N:1 data multiplexer with per-channel valid/ready handshakes, round-robin or fixed-priority arbitration, and a registered output stage. It generalises the combinational 2:1 select to a clocked, flow-controlled selector. It merges several producers, such as bus masters or result ports, onto one downstream consumer. The block is self-contained: one clock domain, no memories.

## Interface
- `BITS`, default 8: payload width per channel, ≥1.
- `CHANNELS`, default 4: number of input channels, 2..16.
- `FIXED_PRIORITY`, default 0:
  - 0: round-robin arbitration.
  - 1: lowest-index channel always wins.
- `CW`, derived, = max(1, $clog2(CHANNELS)): channel index width; not overridden.

Ports:
- `clk` input 1: single clock; all state updates on rising edge.
- `reset_n` input 1: synchronous, active-low reset, sampled on rising edge of `clk`.
- `in_valid` input CHANNELS: bit i = channel i offers data.
- `in_data` input CHANNELS*BITS: channel i payload at bits [i*BITS +: BITS].
- `in_ready` output CHANNELS: bit i = channel i transfers this cycle; at most one bit set.
- `out_valid` output 1: output register holds a word.
- `out_data` output BITS: registered payload.
- `out_channel` output CW: source channel index of `out_data`.
- `out_ready` input 1: downstream accepts the output word this cycle.

## Operation
- Registers: `out_valid`, `out_data`, `out_channel`, and `last` (CW bits, index of the last granted channel).
- `accept = !out_valid || out_ready`: the output register can load this cycle.
- Grant selection, combinational from `in_valid` and `last`:
  - Round-robin: scan indices `last+1, last+2, …` modulo CHANNELS; the first valid channel wins. Channel `last` is considered last.
  - Fixed priority: lowest set index of `in_valid` wins; `last` is still updated but unused.
  - No channel valid: no grant.
- `in_ready[g] = accept && grant exists && g == grant`; all other bits are 0.
- `in_ready` may depend combinationally on `in_valid` and `out_ready`. Sources must not gate `in_valid` on `in_ready`.
- Source rule: once `in_valid[i]` is asserted, it and `in_data[i]` stay stable until `in_ready[i]` is high. The block does not check this.
- Transfer (`in_ready[g]` high), at the clock edge:
  - `out_valid <= 1`
  - `out_data <= in_data[g]`
  - `out_channel <= g`
  - `last <= g`
- `accept` high with no grant: `out_valid <= 0`. `out_data`, `out_channel` and `last` hold.
- `accept` low: all registers hold.
- Output handshake: a word leaves when `out_valid && out_ready`. If a new transfer happens in the same cycle, it replaces the word with no bubble.
- Reset (`reset_n` low at a rising edge):
  - `out_valid = 0`, `out_data = 0`, `out_channel = 0`.
  - `last = CHANNELS-1`, so channel 0 has first round-robin priority.
  - `in_ready` is 0 during any cycle in which `reset_n` is low.
- Reset mid-operation discards the held output word. Any source whose handshake did not complete keeps its request pending.
- Non-power-of-2 CHANNELS: the scan wraps at CHANNELS-1 → 0. Indices ≥ CHANNELS never appear on `out_channel` or in `last`.

## Timing
- Latency: 1 cycle from `in_valid[i] && in_ready[i]` at edge k to `out_valid`/`out_data` visible after edge k.
- Throughput: 1 word per cycle while `out_ready` stays high.
- Backpressure: with `out_valid=1` and `out_ready=0`, all `in_ready` are 0 in the same cycle. Outputs hold.
- Fairness (round-robin): a continuously valid channel is granted within CHANNELS transfers.
- No combinational path from any input to `out_valid`, `out_data` or `out_channel`.

## Test plan
- Reset, CHANNELS=4, BITS=8:
  - After the reset edge: `out_valid=0`, `out_data=0x00`, `out_channel=0`.
  - Then all `in_valid=4'b1111` with `out_ready=1`: first transfer is from channel 0.
- Round-robin streaming: all 4 channels valid, channel i data = 0x10+i, `out_ready=1` → `out_channel` sequence is 0,1,2,3,0,1 on consecutive cycles, with matching `out_data` 0x10..0x13.
- Backpressure:
  - `out_valid=1` (channel 1, 0x11); hold `out_ready=0` for 3 cycles → `in_ready=0`, outputs stable.
  - Raise `out_ready` → channel 2 transfers that cycle; `out_data=0x12` next cycle.
- Wrap and gaps:
  - Only channel 2 valid for 3 cycles → 3 grants to channel 2.
  - Then channels 1 and 3 valid → order is 3, then 1.
  - Then no inputs with `out_ready=1` → `out_valid` drops to 0 after one cycle.
- Fixed priority: `FIXED_PRIORITY=1`, channels 1 and 3 held valid, `out_ready=1` → channel 1 granted every cycle for 8 cycles; `in_ready[3]` stays 0.
- Mid-operation reset: streaming as in the round-robin scenario, then `reset_n=0` for one edge → next cycle `out_valid=0` and `in_ready=0` throughout. After release, with all channels valid, first grant is channel 0.

Source files
------------

// File: rtl/rr_mux.sv
// rr_mux: N:1 valid/ready multiplexer with round-robin or fixed-priority
// arbitration and a single registered output stage (out_valid/out_data/
// out_channel). in_ready is combinational from in_valid, out_ready and the
// registered state; the outputs are driven only from registers.
module rr_mux #(
  parameter int BITS           = 8,
  parameter int CHANNELS       = 4,
  parameter int FIXED_PRIORITY = 0,
  localparam int CW            = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [CHANNELS-1:0]      in_valid,
  input  logic [CHANNELS*BITS-1:0] in_data,
  output logic [CHANNELS-1:0]      in_ready,
  output logic                     out_valid,
  output logic [BITS-1:0]          out_data,
  output logic [CW-1:0]            out_channel,
  input  logic                     out_ready
);

  // Lowest set bit of vec, returned as {found, index}.
  function automatic logic [CW:0] find_first(input logic [CHANNELS-1:0] vec);
    logic [CW:0] res;
    res = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      res = vec[i] ? {1'b1, CW'(i)} : res;
    end
    return res;
  endfunction

  logic                r_out_valid;
  logic [BITS-1:0]     r_out_data;
  logic [CW-1:0]       r_out_channel;
  logic [CW-1:0]       r_last;

  logic [CHANNELS-1:0] w_above_last;
  logic [CW:0]         w_hi;
  logic [CW:0]         w_lo;
  logic [CW:0]         w_low_first;
  logic                w_grant_found;
  logic [CW-1:0]       w_grant_idx;
  logic                w_accept;
  logic                w_xfer;
  logic [BITS-1:0]     w_sel_data;

  // Arbitration: round-robin prefers channels above r_last (lowest first),
  // then wraps to channels 0..r_last, so r_last itself is considered last.
  always_comb begin
    w_above_last = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_above_last[i] = (CW'(i) > r_last);
    end
    w_hi        = find_first(in_valid & w_above_last);
    w_lo        = find_first(in_valid & ~w_above_last);
    w_low_first = find_first(in_valid);
    if (FIXED_PRIORITY != 0) begin
      w_grant_found = w_low_first[CW];
      w_grant_idx   = w_low_first[CW-1:0];
    end else if (w_hi[CW]) begin
      w_grant_found = 1'b1;
      w_grant_idx   = w_hi[CW-1:0];
    end else begin
      w_grant_found = w_lo[CW];
      w_grant_idx   = w_lo[CW-1:0];
    end
  end

  // Handshake decode: one-hot in_ready for the granted channel, payload select.
  always_comb begin
    w_accept   = !r_out_valid || out_ready;
    w_xfer     = reset_n && w_accept && w_grant_found;
    w_sel_data = '0;
    in_ready   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_sel_data  = (CW'(i) == w_grant_idx) ? in_data[i*BITS +: BITS] : w_sel_data;
      in_ready[i] = w_xfer && (CW'(i) == w_grant_idx);
    end
  end

  // Output register and round-robin pointer; reset parks the pointer on the
  // top channel so channel 0 wins the first round-robin scan.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_out_channel <= '0;
      r_last        <= CW'(CHANNELS - 1);
    end else if (w_accept) begin
      if (w_grant_found) begin
        r_out_valid   <= 1'b1;
        r_out_data    <= w_sel_data;
        r_out_channel <= w_grant_idx;
        r_last        <= w_grant_idx;
      end else begin
        r_out_valid   <= 1'b0;
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_channel = r_out_channel;

endmodule
